// File: rtl/button_pkg.sv
// Shared polarity constants and timer sizing helper for the button event counter.
package button_pkg;

   localparam logic BUTTON_PRESSED  = 1'b1;
   localparam logic BUTTON_RELEASED = 1'b0;

   function automatic int clog2_plus1(input int max_value);
      return $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce, long-press detection and event pulses.
// Auto-repeat is compiled in only when BUTTON_EVENT_COUNTER_AUTOREPEAT_EN is defined.
module button_debounce_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CLOCK_PERIODS   = 1678,
   parameter int LONG_PRESS_CLOCK_PERIODS = 1600000,
   parameter int REPEAT_CLOCK_PERIODS     = 400000,
   parameter int ACTIVE_LOW               = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic button_raw,
   output logic button_state,
   output logic went_active,
   output logic went_inactive,
   output logic long_press
);

   localparam int DW = clog2_plus1(DEBOUNCE_CLOCK_PERIODS);
   localparam int HW = clog2_plus1(LONG_PRESS_CLOCK_PERIODS);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CLOCK_PERIODS - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CLOCK_PERIODS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CLOCK_PERIODS - 1);

   if (DEBOUNCE_CLOCK_PERIODS < 2 || LONG_PRESS_CLOCK_PERIODS < 2 || REPEAT_CLOCK_PERIODS < 2) begin : g_bad_params
      $error("button_debounce_channel: timer parameters must be >= 2");
   end

   logic          raw_level;
   logic          sync_a;
   logic          sync_b;
   logic [DW-1:0] deb_timer;
   logic [HW-1:0] hold_timer;
   logic          accept;
   logic          hold_done;
   logic          rep_fire;

   assign raw_level = (ACTIVE_LOW != 0) ? ~button_raw : button_raw;
   assign accept    = (sync_b != button_state) && (deb_timer == DEB_LAST);
   assign hold_done = (button_state == BUTTON_PRESSED) && (hold_timer == HOLD_MAX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_a        <= 1'b0;
         sync_b        <= 1'b0;
         deb_timer     <= '0;
         button_state  <= BUTTON_RELEASED;
         went_active   <= 1'b0;
         went_inactive <= 1'b0;
      end else begin
         sync_a <= raw_level;
         sync_b <= sync_a;
         if (sync_b == button_state || accept)
            deb_timer <= '0;
         else
            deb_timer <= deb_timer + 1'b1;
         if (accept)
            button_state <= ~button_state;
         // a repeat coinciding with an accepted release is dropped
         went_active   <= (accept && button_state == BUTTON_RELEASED) || (rep_fire && !accept);
         went_inactive <= accept && button_state == BUTTON_PRESSED;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_timer <= '0;
         long_press <= 1'b0;
      end else begin
         if (button_state == BUTTON_RELEASED)
            hold_timer <= '0;
         else if (!hold_done)
            hold_timer <= hold_timer + 1'b1;
         long_press <= (button_state == BUTTON_PRESSED) && (hold_timer == HOLD_LAST);
      end
   end

`ifdef BUTTON_EVENT_COUNTER_AUTOREPEAT_EN
   localparam int RW = clog2_plus1(REPEAT_CLOCK_PERIODS);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CLOCK_PERIODS - 1);

   logic [RW-1:0] rep_timer;

   assign rep_fire = hold_done && (rep_timer == REP_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         rep_timer <= '0;
      else if (!hold_done || rep_fire)
         rep_timer <= '0;
      else
         rep_timer <= rep_timer + 1'b1;
   end
`else
   assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/button_event_counter.sv
// NUM_BUTTONS independent debounced buttons with event pulses and wrapping press counters.
// Optional auto-repeat: define BUTTON_EVENT_COUNTER_AUTOREPEAT_EN.
module button_event_counter
   import button_pkg::*;
#(
   parameter int NUM_BUTTONS              = 2,
   parameter int DEBOUNCE_CLOCK_PERIODS   = 1678,
   parameter int LONG_PRESS_CLOCK_PERIODS = 1600000,
   parameter int REPEAT_CLOCK_PERIODS     = 400000,
   parameter int COUNT_WIDTH              = 8,
   parameter int ACTIVE_LOW               = 0
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_BUTTONS-1:0]             button_raw,
   input  logic [NUM_BUTTONS-1:0]             count_clear,
   output logic [NUM_BUTTONS-1:0]             button_state,
   output logic [NUM_BUTTONS-1:0]             button_just_went_active,
   output logic [NUM_BUTTONS-1:0]             button_just_went_inactive,
   output logic [NUM_BUTTONS-1:0]             button_long_press,
   output logic [NUM_BUTTONS*COUNT_WIDTH-1:0] press_count
);

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      logic [COUNT_WIDTH-1:0] count;

      button_debounce_channel #(
         .DEBOUNCE_CLOCK_PERIODS   (DEBOUNCE_CLOCK_PERIODS),
         .LONG_PRESS_CLOCK_PERIODS (LONG_PRESS_CLOCK_PERIODS),
         .REPEAT_CLOCK_PERIODS     (REPEAT_CLOCK_PERIODS),
         .ACTIVE_LOW               (ACTIVE_LOW)
      ) u_channel (
         .clock         (clock),
         .reset         (reset),
         .button_raw    (button_raw[i]),
         .button_state  (button_state[i]),
         .went_active   (button_just_went_active[i]),
         .went_inactive (button_just_went_inactive[i]),
         .long_press    (button_long_press[i])
      );

      // counts the registered pulse, so a clear during the pulse cycle wins
      always_ff @(posedge clock or posedge reset) begin
         if (reset)
            count <= '0;
         else if (count_clear[i])
            count <= '0;
         else if (button_just_went_active[i])
            count <= count + 1'b1;
      end

      assign press_count[i*COUNT_WIDTH +: COUNT_WIDTH] = count;
   end

endmodule
